mul_div_sequencer: RTL and testbench

Iterative multiply/divide sequencer that owns the architectural HI and LO registers of the MIPS core. It is started by the execute stage for MULT/MULTU/DIV/DIVU (funct 011000/011001/011010/011011) and services MTHI/MTLO (010001/010011) directly. It reports `busy`, and it stalls the pipeline when MFHI/MFLO arrive before a result is ready. It replaces single-cycle HI/LO arithmetic in the ALU, computing one result bit per cycle.

---
 rtl/mul_div_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mul_div_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_sequencer.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO writes.
// Latency: mult/div result in HI/LO 33 cycles after acceptance; MTHI/MTLO on the accepting edge.
// Backpressure: busy blocks every start; stall = busy & hi_lo_read holds MFHI/MFLO in execute.
module mul_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_lo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  state_t state, next_state;

  // acc holds {upper partial product, multiplier} for MUL and {rem, quot} for DIV
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;   // multiplicand or divisor magnitude
  logic [CW-1:0]      count;
  logic               op_div;
  logic               neg_q;   // negate product (mult) or quotient (div)
  logic               neg_r;   // negate remainder

  // Instruction decode, only meaningful while idle
  logic is_mult, is_div, is_signed, accept, div_zero;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs, a_load;

  // Decode and operand magnitude conditioning
  always_comb begin
    is_mult   = (funct == F_MULT) || (funct == F_MULTU);
    is_div    = (funct == F_DIV)  || (funct == F_DIVU);
    is_signed = (funct == F_MULT) || (funct == F_DIV);
    accept    = (state == IDLE) && start && (is_mult || is_div);
    div_zero  = is_div && (operand_b == '0);
    a_neg     = is_signed && operand_a[WIDTH-1];
    b_neg     = is_signed && operand_b[WIDTH-1];
    a_abs     = a_neg ? -operand_a : operand_a;
    b_abs     = b_neg ? -operand_b : operand_b;
    // With a zero divisor the raw dividend falls out as the remainder and the
    // quotient saturates to all ones, so no separate copy of operand_a is kept.
    a_load    = div_zero ? operand_a : a_abs;
  end

  // One multiply step, one restoring-divide step and the final sign fixup
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted_rem;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Datapath arithmetic for the current iteration
  always_comb begin
    mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next    = {mul_sum, acc[WIDTH-1:1]};
    shifted_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge      = shifted_rem >= {1'b0, mcand};
    // Difference is below the divisor whenever it is kept, so WIDTH bits suffice
    div_diff    = shifted_rem[WIDTH-1:0] - mcand;
    div_next    = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                         : {shifted_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    prod_fix    = neg_q ? -acc : acc;
    quot_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = is_div ? DIV : MUL;
      MUL:     if (count == LAST_ITER) next_state = FIXUP;
      DIV:     if (count == LAST_ITER) next_state = FIXUP;
      FIXUP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs; stall has no register so MFHI/MFLO resumes in the done cycle
  always_comb begin
    busy  = (state != IDLE);
    stall = busy && hi_lo_read;
  end

  // Operand latch, iteration, HI/LO write-back and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      count  <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            count  <= '0;
            op_div <= is_div;
            acc    <= {{WIDTH{1'b0}}, is_div ? a_load : b_abs};
            mcand  <= is_div ? b_abs : a_abs;
            neg_q  <= (a_neg ^ b_neg) && !div_zero;
            neg_r  <= is_div && a_neg && !div_zero;
          end else if (start && funct == F_MTHI) begin
            hi <= operand_a;
          end else if (start && funct == F_MTLO) begin
            lo <= operand_a;
          end
        end
        MUL: begin
          acc   <= mul_next;
          count <= count + CW'(1);
        end
        DIV: begin
          acc   <= div_next;
          count <= count + CW'(1);
        end
        FIXUP: begin
          if (op_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: directed corner cases plus randomized ops against an arithmetic model.
// Latency: checks 33-cycle result latency and 33-cycle busy window per operation.
// Backpressure: checks stall, ignored starts while busy, and the earliest back-to-back accept.
module tb_mul_div_sequencer;

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        hi_lo_read = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int pass_cnt = 0;
  int total = 0;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .operand_a(operand_a), .operand_b(operand_b), .hi_lo_read(hi_lo_read),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  // Architectural result {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] t1, t2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    model = '0;
    case (f)
      F_MULT:  begin t1 = sa * sb; model = t1; end
      F_MULTU: begin t1 = ua * ub; model = t1; end
      F_DIV: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb; sr = sa % sb;
          t1 = sq; t2 = sr;
          model = {t2[31:0], t1[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub; ur = ua % ub;
          t1 = uq; t2 = ur;
          model = {t2[31:0], t1[31:0]};
        end
      end
      default: model = '0;
    endcase
  endfunction

  // Present one instruction for one cycle; returns at the negedge after the accepting edge
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct = f; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; funct = '0; operand_a = $urandom; operand_b = $urandom;
  endtask

  // Counts edges after acceptance until done, bounded
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int lat, bcnt;
    logic [63:0] exp;
    exp = model(f, a, b);
    issue(f, a, b);
    wait_done(lat, bcnt);
    total++; if (lat !== 33) $display("FAIL %s latency got %0d want 33", name, lat); else pass_cnt++;
    total++; if (bcnt !== 33) $display("FAIL %s busy_cycles got %0d want 33", name, bcnt); else pass_cnt++;
    total++; if (hi !== exp[63:32]) $display("FAIL %s hi got %h want %h (a=%h b=%h)", name, hi, exp[63:32], a, b); else pass_cnt++;
    total++; if (lo !== exp[31:0]) $display("FAIL %s lo got %h want %h (a=%h b=%h)", name, lo, exp[31:0], a, b); else pass_cnt++;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s after_done done=%b busy=%b want 0 0", name, done, busy); else pass_cnt++;
  endtask

  task automatic test_reset;
    hi_lo_read = 1'b1;
    @(negedge clk);
    total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo got %h %h want 0 0", hi, lo); else pass_cnt++;
    total++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) $display("FAIL reset_flags busy=%b done=%b stall=%b want 000", busy, done, stall); else pass_cnt++;
    reset = 1'b0;
    hi_lo_read = 1'b0;
  endtask

  task automatic test_directed;
    test_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_max_const got %h want fffffffe00000001", {hi, lo}); else pass_cnt++;
    test_op("mult_neg", F_MULT, -32'sd3, 32'd7);
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL mult_neg_const got %h want ffffffffffffffeb", {hi, lo}); else pass_cnt++;
    test_op("div_neg", F_DIV, -32'sd7, 32'd2);
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg_const got %h want fffffffffffffffd", {hi, lo}); else pass_cnt++;
    test_op("divu_zero", F_DIVU, 32'd10, 32'd0);
    total++; if ({hi, lo} !== 64'h0000_000A_FFFF_FFFF) $display("FAIL divu_zero_const got %h want 0000000affffffff", {hi, lo}); else pass_cnt++;
    test_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) $display("FAIL div_ovf_const got %h want 0000000080000000", {hi, lo}); else pass_cnt++;
    test_op("div_zero_signed", F_DIV, 32'hFFFF_FFF9, 32'd0);
  endtask

  task automatic test_mthi_mtlo;
    issue(F_MTHI, 32'h1234_5678, 32'h0);
    total++; if (hi !== 32'h1234_5678) $display("FAIL mthi got %h want 12345678", hi); else pass_cnt++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mthi_flags busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
    issue(F_MTLO, 32'hCAFE_BABE, 32'h0);
    total++; if (lo !== 32'hCAFE_BABE || hi !== 32'h1234_5678) $display("FAIL mtlo got hi=%h lo=%h want 12345678 cafebabe", hi, lo); else pass_cnt++;
  endtask

  // Busy window: stall, ignored starts, old HI/LO held, start at FIXUP edge, back-to-back accept
  task automatic test_stall_busy;
    int idx, stall_bad, lat, bcnt;
    logic [31:0] a, b, p, q;
    logic [63:0] exp;
    a = $urandom; b = $urandom;
    p = $urandom | 32'h1; q = $urandom | 32'h1;
    exp = model(F_MULT, a, b);
    hi_lo_read = 1'b1;
    issue(F_MULT, a, b);
    idx = 0; stall_bad = 0;
    while (!done && idx < 60) begin
      if (stall !== 1'b1) stall_bad++;
      if (idx == 20) begin
        total++; if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE) $display("FAIL busy_hold got %h %h want 12345678 cafebabe", hi, lo); else pass_cnt++;
      end
      start = 1'b0;
      if (idx == 5)  begin start = 1'b1; funct = F_MTLO;  operand_a = 32'hDEAD_BEEF; end
      if (idx == 10) begin start = 1'b1; funct = F_MULTU; operand_a = 32'd5; operand_b = 32'd9; end
      if (idx == 32) begin start = 1'b1; funct = F_DIVU;  operand_a = 32'd100; operand_b = 32'd7; end
      @(negedge clk);
      idx++;
    end
    total++; if (idx !== 33) $display("FAIL stall_latency got %0d want 33", idx); else pass_cnt++;
    total++; if (stall_bad !== 0) $display("FAIL stall_busy got %0d low cycles want 0", stall_bad); else pass_cnt++;
    total++; if (stall !== 1'b0) $display("FAIL stall_done got %b want 0", stall); else pass_cnt++;
    total++; if ({hi, lo} !== exp) $display("FAIL busy_ignore got %h want %h", {hi, lo}, exp); else pass_cnt++;
    // Earliest legal accept: start held through the done cycle
    funct = F_MULTU; operand_a = p; operand_b = q; start = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_lo_read = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept busy got %b want 1", busy); else pass_cnt++;
    exp = model(F_MULTU, p, q);
    wait_done(lat, bcnt);
    total++; if (lat !== 33) $display("FAIL b2b_latency got %0d want 33", lat); else pass_cnt++;
    total++; if ({hi, lo} !== exp) $display("FAIL b2b_result got %h want %h", {hi, lo}, exp); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(F_DIV, -32'sd1000, 32'd7);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL mid_reset_hilo got %h %h want 0 0", hi, lo); else pass_cnt++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_reset_flags busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) $display("FAIL mid_reset_no_done got %0d active cycles want 0", seen); else pass_cnt++;
    test_op("after_reset_multu", F_MULTU, 32'd2, 32'd3);
    total++; if (lo !== 32'd6 || hi !== 32'd0) $display("FAIL after_reset_const got %h %h want 0 6", hi, lo); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [5:0] f;
    logic [31:0] a, b;
    int sel;
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 3);
      f = (sel == 0) ? F_MULT : (sel == 1) ? F_MULTU : (sel == 2) ? F_DIV : F_DIVU;
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 16);
        3: b = -$urandom_range(1, 16);
        default: ;
      endcase
      test_op("random", f, a, b);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_mthi_mtlo;
    test_stall_busy;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
